// File: rtl/lcd_master_b2p_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_master_b2p_adapter_if
// Description : Stream bundle for the LCD master b2p channel adapter.
//               Carries the channelised input stream and the plain output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_master_b2p_adapter_if #(
    parameter int DATA_W    = 8,
    parameter int CHANNEL_W = 8
);
    logic                 in_ready;
    logic                 in_valid;
    logic [DATA_W-1:0]    in_data;
    logic [CHANNEL_W-1:0] in_channel;
    logic                 in_startofpacket;
    logic                 in_endofpacket;

    logic                 out_ready;
    logic                 out_valid;
    logic [DATA_W-1:0]    out_data;
    logic                 out_startofpacket;
    logic                 out_endofpacket;

    // Adapter side.
    modport master (
        output in_ready,
        input  in_valid,
        input  in_data,
        input  in_channel,
        input  in_startofpacket,
        input  in_endofpacket,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_startofpacket,
        output out_endofpacket
    );

    // Environment side: upstream source and downstream sink.
    modport slave (
        input  in_ready,
        output in_valid,
        output in_data,
        output in_channel,
        output in_startofpacket,
        output in_endofpacket,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_startofpacket,
        input  out_endofpacket
    );
endinterface
`default_nettype wire

// File: rtl/lcd_master_b2p_adapter.sv
`default_nettype none
// ============================================================================
// Module      : lcd_master_b2p_adapter
// Description : Filters one channel out of a channelised byte stream into a
//               plain skid-buffered packet stream with drop statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_master_b2p_adapter #(
    parameter int DATA_W     = 8,
    parameter int CHANNEL_W  = 8,
    parameter int CHANNEL_ID = 0,
    parameter int CNT_W      = 16
) (
    input  wire                         clk,
    input  wire                         reset_n,
    lcd_master_b2p_adapter_if.master    bus,
    output logic [CNT_W-1:0]            pkt_drop_count,
    output logic [CNT_W-1:0]            orphan_count,
    output logic                        framing_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PASS = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [CHANNEL_W-1:0] c_channel_id = CHANNEL_W'(CHANNEL_ID);
    localparam logic [CNT_W-1:0]     c_cnt_max    = '1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_sop;
    logic              r_out_eop;

    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_sop;
    logic              r_skid_eop;

    logic [CNT_W-1:0]  r_drop_cnt;
    logic [CNT_W-1:0]  r_orphan_cnt;
    logic              r_framing_err;

    logic              w_accept;
    logic              w_chan_match;
    logic              w_fwd;
    logic              w_drop_pkt;
    logic              w_orphan;
    logic              w_ferr;
    logic              w_out_free;
    logic              w_skid_valid_next;

    assign w_accept     = bus.in_valid && r_in_ready;
    assign w_chan_match = (bus.in_channel == c_channel_id);
    assign w_out_free   = !r_out_valid || bus.out_ready;

    // ------------------------------------------------------------------
    // Packet framing FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: an SOP always restarts framing, whatever state we are in.
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            if (bus.in_startofpacket) begin
                if (bus.in_endofpacket) begin
                    w_state_next = S_IDLE;
                end else if (w_chan_match) begin
                    w_state_next = S_PASS;
                end else begin
                    w_state_next = S_DROP;
                end
            end else begin
                case (r_state)
                    S_PASS:  w_state_next = bus.in_endofpacket ? S_IDLE : S_PASS;
                    S_DROP:  w_state_next = bus.in_endofpacket ? S_IDLE : S_DROP;
                    default: w_state_next = S_IDLE;
                endcase
            end
        end
    end

    // Per-beat decisions
    always_comb begin
        w_fwd      = 1'b0;
        w_drop_pkt = 1'b0;
        w_orphan   = 1'b0;
        w_ferr     = 1'b0;
        if (w_accept) begin
            if (bus.in_startofpacket) begin
                // SOP while inside a packet truncates the old one.
                w_ferr     = (r_state == S_PASS) || (r_state == S_DROP);
                w_fwd      = w_chan_match;
                w_drop_pkt = !w_chan_match;
            end else begin
                case (r_state)
                    S_PASS: w_fwd = 1'b1;
                    S_DROP: w_fwd = 1'b0;
                    default: begin
                        w_orphan = 1'b1;
                        w_ferr   = 1'b1;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register plus one-entry skid buffer
    // ------------------------------------------------------------------
    // A full skid blocks input, so the skid only fills while the output
    // register is stalled and drains as soon as the output frees up.
    assign w_skid_valid_next = w_out_free ? 1'b0 : (r_skid_valid || w_fwd);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sop    <= 1'b0;
            r_out_eop    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_sop   <= 1'b0;
            r_skid_eop   <= 1'b0;
        end else begin
            r_skid_valid <= w_skid_valid_next;
            r_in_ready   <= !w_skid_valid_next;
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_skid_data;
                    r_out_sop   <= r_skid_sop;
                    r_out_eop   <= r_skid_eop;
                end else if (w_fwd) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= bus.in_data;
                    r_out_sop   <= bus.in_startofpacket;
                    r_out_eop   <= bus.in_endofpacket;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_fwd) begin
                r_skid_data <= bus.in_data;
                r_skid_sop  <= bus.in_startofpacket;
                r_skid_eop  <= bus.in_endofpacket;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics and error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_drop_cnt    <= '0;
            r_orphan_cnt  <= '0;
            r_framing_err <= 1'b0;
        end else begin
            r_framing_err <= w_ferr;
            if (w_drop_pkt && (r_drop_cnt != c_cnt_max)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (w_orphan && (r_orphan_cnt != c_cnt_max)) begin
                r_orphan_cnt <= r_orphan_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready          = r_in_ready;
    assign bus.out_valid         = r_out_valid;
    assign bus.out_data          = r_out_data;
    assign bus.out_startofpacket = r_out_sop;
    assign bus.out_endofpacket   = r_out_eop;
    assign pkt_drop_count        = r_drop_cnt;
    assign orphan_count          = r_orphan_cnt;
    assign framing_err           = r_framing_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_master_b2p_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_master_b2p_adapter
// Description : Directed self-checking bench for lcd_master_b2p_adapter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lcd_master_b2p_adapter;

    localparam int c_data_w = 8;
    localparam int c_chan_w = 8;
    localparam int c_cnt_w  = 16;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [c_cnt_w-1:0] pkt_drop_count;
    logic [c_cnt_w-1:0] orphan_count;
    logic               framing_err;

    int checks = 0;
    int errors = 0;

    lcd_master_b2p_adapter_if #(.DATA_W(c_data_w), .CHANNEL_W(c_chan_w)) bus ();

    lcd_master_b2p_adapter #(
        .DATA_W    (c_data_w),
        .CHANNEL_W (c_chan_w),
        .CHANNEL_ID(0),
        .CNT_W     (c_cnt_w)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus.master),
        .pkt_drop_count(pkt_drop_count),
        .orphan_count  (orphan_count),
        .framing_err   (framing_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic [7:0] ch, input logic sop, input logic eop);
        bus.in_valid         = 1'b1;
        bus.in_data          = d;
        bus.in_channel       = ch;
        bus.in_startofpacket = sop;
        bus.in_endofpacket   = eop;
    endtask

    task automatic idle();
        bus.in_valid         = 1'b0;
        bus.in_startofpacket = 1'b0;
        bus.in_endofpacket   = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                           input logic s, input logic e);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        if (v) begin
            chk({tag, "_data"}, {24'd0, bus.out_data}, {24'd0, d});
            chk({tag, "_flags"}, {30'd0, bus.out_startofpacket, bus.out_endofpacket}, {30'd0, s, e});
        end
    endtask

    initial begin
        bus.out_ready  = 1'b1;
        bus.in_data    = '0;
        bus.in_channel = '0;
        idle();

        // Reset state
        reset_n = 1'b0;
        tick(); tick();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk_out("rst_out", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        chk("rst_drop", {16'd0, pkt_drop_count}, 32'd0);
        chk("rst_orphan", {16'd0, orphan_count}, 32'd0);
        chk("rst_ferr", {31'd0, framing_err}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // 4-beat packet on channel 0, one-cycle latency
        beat(8'h11, 8'd0, 1'b1, 1'b0); tick(); chk_out("p1_b0", 1'b1, 8'h11, 1'b1, 1'b0);
        beat(8'h22, 8'd0, 1'b0, 1'b0); tick(); chk_out("p1_b1", 1'b1, 8'h22, 1'b0, 1'b0);
        beat(8'h33, 8'd7, 1'b0, 1'b0); tick(); chk_out("p1_b2", 1'b1, 8'h33, 1'b0, 1'b0);
        beat(8'h44, 8'd0, 1'b0, 1'b1); tick(); chk_out("p1_b3", 1'b1, 8'h44, 1'b0, 1'b1);
        chk("p1_in_ready", {31'd0, bus.in_ready}, 32'd1);
        idle(); tick();
        chk_out("p1_end", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("p1_drop", {16'd0, pkt_drop_count}, 32'd0);
        chk("p1_orphan", {16'd0, orphan_count}, 32'd0);

        // Channel 5 packet dropped whole, channel 0 packet passes
        beat(8'h50, 8'd5, 1'b1, 1'b0); tick(); chk_out("d_b0", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("d_in_ready", {31'd0, bus.in_ready}, 32'd1);
        beat(8'h51, 8'd0, 1'b0, 1'b0); tick(); chk_out("d_b1", 1'b0, 8'h00, 1'b0, 1'b0);
        beat(8'h52, 8'd5, 1'b0, 1'b1); tick(); chk_out("d_b2", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("d_drop", {16'd0, pkt_drop_count}, 32'd1);
        beat(8'h60, 8'd0, 1'b1, 1'b0); tick(); chk_out("d_p2_b0", 1'b1, 8'h60, 1'b1, 1'b0);
        beat(8'h61, 8'd0, 1'b0, 1'b1); tick(); chk_out("d_p2_b1", 1'b1, 8'h61, 1'b0, 1'b1);
        idle(); tick();
        chk_out("d_end", 1'b0, 8'h00, 1'b0, 1'b0);

        // Backpressure through the skid buffer
        bus.out_ready = 1'b0;
        beat(8'h71, 8'd0, 1'b1, 1'b0); tick(); chk_out("bp_a1", 1'b1, 8'h71, 1'b1, 1'b0);
        chk("bp_rdy1", {31'd0, bus.in_ready}, 32'd1);
        beat(8'h72, 8'd0, 1'b0, 1'b0); tick(); chk_out("bp_a2", 1'b1, 8'h71, 1'b1, 1'b0);
        chk("bp_rdy2", {31'd0, bus.in_ready}, 32'd0);
        beat(8'h73, 8'd0, 1'b0, 1'b1); tick(); chk_out("bp_hold", 1'b1, 8'h71, 1'b1, 1'b0);
        chk("bp_rdy3", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        tick(); chk_out("bp_o2", 1'b1, 8'h72, 1'b0, 1'b0);
        chk("bp_rdy4", {31'd0, bus.in_ready}, 32'd1);
        tick(); chk_out("bp_o3", 1'b1, 8'h73, 1'b0, 1'b1);
        idle(); tick();
        chk_out("bp_end", 1'b0, 8'h00, 1'b0, 1'b0);

        // Orphan beat in IDLE
        beat(8'hAA, 8'd0, 1'b0, 1'b0); tick();
        chk_out("or_out", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("or_ferr", {31'd0, framing_err}, 32'd1);
        chk("or_cnt", {16'd0, orphan_count}, 32'd1);
        idle(); tick();
        chk("or_ferr_off", {31'd0, framing_err}, 32'd0);
        beat(8'h81, 8'd0, 1'b1, 1'b0); tick(); chk_out("or_p_b0", 1'b1, 8'h81, 1'b1, 1'b0);
        beat(8'h82, 8'd0, 1'b0, 1'b1); tick(); chk_out("or_p_b1", 1'b1, 8'h82, 1'b0, 1'b1);
        idle(); tick();

        // SOP arriving mid-packet truncates the old packet
        beat(8'h91, 8'd0, 1'b1, 1'b0); tick(); chk_out("tr_b0", 1'b1, 8'h91, 1'b1, 1'b0);
        beat(8'h92, 8'd0, 1'b0, 1'b0); tick(); chk_out("tr_b1", 1'b1, 8'h92, 1'b0, 1'b0);
        chk("tr_ferr0", {31'd0, framing_err}, 32'd0);
        beat(8'hA1, 8'd0, 1'b1, 1'b0); tick(); chk_out("tr_n0", 1'b1, 8'hA1, 1'b1, 1'b0);
        chk("tr_ferr1", {31'd0, framing_err}, 32'd1);
        beat(8'hA2, 8'd0, 1'b0, 1'b1); tick(); chk_out("tr_n1", 1'b1, 8'hA2, 1'b0, 1'b1);
        chk("tr_ferr2", {31'd0, framing_err}, 32'd0);
        idle(); tick();

        // Reset mid-packet with a beat in the skid
        beat(8'hB1, 8'd0, 1'b1, 1'b0); tick();
        bus.out_ready = 1'b0;
        beat(8'hB2, 8'd0, 1'b0, 1'b0); tick();
        chk("mr_skid_full", {31'd0, bus.in_ready}, 32'd0);
        idle();
        reset_n = 1'b0;
        tick();
        chk("mr_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("mr_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mr_out_data", {24'd0, bus.out_data}, 32'd0);
        chk("mr_out_flags", {30'd0, bus.out_startofpacket, bus.out_endofpacket}, 32'd0);
        chk("mr_drop", {16'd0, pkt_drop_count}, 32'd0);
        chk("mr_orphan", {16'd0, orphan_count}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("mr_ready_back", {31'd0, bus.in_ready}, 32'd1);
        // State is IDLE again, so a non-SOP beat is an orphan
        beat(8'hB3, 8'd0, 1'b0, 1'b0); tick();
        chk("mr_orphan1", {16'd0, orphan_count}, 32'd1);
        chk("mr_no_out", {31'd0, bus.out_valid}, 32'd0);

        // Drop counter saturation (out_ready low: drops ignore backpressure)
        beat(8'hC0, 8'd3, 1'b1, 1'b1);
        for (int i = 0; i < 65535; i++) tick();
        chk("sat_full", {16'd0, pkt_drop_count}, 32'h0000FFFF);
        tick(); tick();
        chk("sat_hold", {16'd0, pkt_drop_count}, 32'h0000FFFF);
        chk("sat_no_out", {31'd0, bus.out_valid}, 32'd0);
        chk("sat_ready", {31'd0, bus.in_ready}, 32'd1);
        idle(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_master_b2p_adapter.md
Name: lcd_master_b2p_adapter

Overview:
- Reverse-direction Avalon-ST channel adapter for the LCD master command path.
- Takes the byte-to-packet converter's channelised stream (data, channel, SOP, EOP) and produces a plain packet stream for the LCD master core.
- Forwards only packets whose channel equals CHANNEL_ID; discards other packets whole.
- Registered, skid-buffered pipeline stage with packet-framing state tracking and drop statistics.

Parameters:
- DATA_W, 8, data beat width
- CHANNEL_W, 8, channel field width
- CHANNEL_ID, 0, channel number accepted; all others dropped
- CNT_W, 16, width of the saturating drop counters

Ports:
- clk  input  1  sole clock
- reset_n  input  1  synchronous active-low reset, sampled on rising clk
- in_ready  output  1  upstream backpressure, registered
- in_valid  input  1  upstream beat valid
- in_data  input  DATA_W  upstream beat data
- in_channel  input  CHANNEL_W  channel tag; significant only on SOP beats
- in_startofpacket  input  1  first beat of packet
- in_endofpacket  input  1  last beat of packet
- out_ready  input  1  downstream ready
- out_valid  output  1  registered beat valid
- out_data  output  DATA_W  registered beat data
- out_startofpacket  output  1  registered SOP
- out_endofpacket  output  1  registered EOP
- pkt_drop_count  output  CNT_W  mismatched-channel packets discarded, saturating
- orphan_count  output  CNT_W  beats discarded while not inside a packet, saturating
- framing_err  output  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (clk edge with reset_n=0):
  - out_valid=0, out_data/out_startofpacket/out_endofpacket=0.
  - in_ready=0 during reset, 1 on the first cycle after reset.
  - Both counters=0, framing_err=0, skid empty, state=IDLE.
- Reset mid-packet aborts all state. Buffered beats are lost with no EOP emitted.
- Input handshake: a beat is accepted when in_valid && in_ready.
- Output handshake: a beat transfers when out_valid && out_ready.
- Datapath:
  - Output register plus one-entry skid register.
  - in_ready = !skid_valid, registered.
  - An accepted forwarded beat loads the output register if it is empty or transferring this cycle; otherwise it loads the skid.
  - The skid drains into the output register on the next transfer.
  - Latency from accepted input beat to out_valid is 1 cycle.
  - Zero bubbles at full throughput with out_ready=1.
  - Data and flags are held stable while out_valid && !out_ready.
- State machine; transitions occur only on accepted beats:
  - IDLE:
    - SOP beat with in_channel==CHANNEL_ID: forward. Next state PASS, or stay IDLE if EOP is also set (single-beat packet).
    - SOP beat with mismatched channel: discard, increment pkt_drop_count. Next state DROP, or IDLE if EOP is also set.
    - Non-SOP beat: discard, increment orphan_count, pulse framing_err. Stay IDLE.
  - PASS:
    - Beat without SOP: forward. EOP returns to IDLE.
    - Beat with SOP: the previous packet is truncated; pulse framing_err, then treat the beat exactly as in IDLE. A new packet's channel is re-evaluated. No synthetic EOP is inserted.
  - DROP:
    - Beat without SOP: discard. EOP returns to IDLE.
    - Beat with SOP: pulse framing_err, then treat as in IDLE.
- in_channel is ignored on non-SOP beats.
- Discarded beats are accepted whenever in_ready=1, independent of out_ready. They never occupy the output or skid registers.
- Counters stop at all-ones and do not wrap.
- framing_err is registered and asserts the cycle after the offending beat is accepted.

Test Plan:
- CHANNEL_ID=0; 4-beat packet 0x11,0x22,0x33,0x44 on channel 0, out_ready=1:
  - out beats identical, SOP on 0x11, EOP on 0x44.
  - First out_valid 1 cycle after first accept.
  - in_ready stays 1; counters stay 0.
- 3-beat packet on channel 5 followed by a 2-beat packet on channel 0:
  - only the 2 channel-0 beats appear at the output.
  - pkt_drop_count=1; channel-5 beats accepted with no out_valid.
- Backpressure: out_ready held 0 while a 3-beat channel-0 packet streams in:
  - in_ready drops after the second accept; out_data holds beat 1.
  - After out_ready=1, beats emerge in order with no loss or duplication.
- Orphan beat 0xAA with no SOP in IDLE → discarded, orphan_count=1, framing_err pulses once. Next valid packet passes intact.
- SOP arrives mid-PASS packet → framing_err pulse; new packet forwarded with SOP, old packet left without EOP.
- reset_n=0 for one cycle mid-packet, then drive out_ready=0 with 0xFFFF preloaded:
  - all outputs return to reset values after the reset edge.
  - Next drop-count test starting from 0xFFFF stays at 0xFFFF (saturation).
